// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the CPU (port 0) and the loader/DMA (port 1).
// Optional ACCESS watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module riscv_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_d;
  logic                m0_gnt_d, m1_gnt_d, m0_done_d, m1_done_d, m0_err_d, m1_err_d;
  logic                mem_re_d, mem_we_d, owner_d, busy_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d, m0_rdata_d, m1_rdata_d;
  logic                winner;

  // Under contention the port that did not win last time goes first
  assign winner = (m0_req && m1_req) ? ~owner : m1_req;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else     tmo_cnt <= tmo_cnt_d;
  end
`endif

  always_comb begin
    state_d     = state;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;
    mem_re_d    = mem_re;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    m0_rdata_d  = m0_rdata;
    m1_rdata_d  = m1_rdata;
    owner_d     = owner;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d     = winner;
          mem_addr_d  = winner ? m1_addr  : m0_addr;
          mem_wdata_d = winner ? m1_wdata : m0_wdata;
          mem_we_d    = winner ? m1_we    : m0_we;
          mem_re_d    = winner ? ~m1_we   : ~m0_we;
          m0_gnt_d    = ~winner;
          m1_gnt_d    = winner;
          state_d     = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          m0_done_d = ~owner;
          m1_done_d = owner;
          // A completed write returns zero rather than whatever the bus carries
          if (owner) m1_rdata_d = mem_we ? '0 : mem_rdata;
          else       m0_rdata_d = mem_we ? '0 : mem_rdata;
          state_d   = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          m0_done_d = ~owner;
          m1_done_d = owner;
          m0_err_d  = ~owner;
          m1_err_d  = owner;
          if (owner) m1_rdata_d = '0;
          else       m0_rdata_d = '0;
          state_d   = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Every output is a flop; the comb block above only computes next values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      state     <= state_d;
      m0_gnt    <= m0_gnt_d;
      m1_gnt    <= m1_gnt_d;
      m0_done   <= m0_done_d;
      m1_done   <= m1_done_d;
      m0_err    <= m0_err_d;
      m1_err    <= m1_err_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      m0_rdata  <= m0_rdata_d;
      m1_rdata  <= m1_rdata_d;
      busy      <= busy_d;
      owner     <= owner_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: cycle vector table plus hand sequences for
// contention, reset during access and the ACCESS watchdog (MEM_ARB_TIMEOUT_EN).
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_re, mem_we, busy, owner;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  riscv_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // flags: {gnt0, gnt1, done0, done1, err0, err1, re, we, busy, owner}
  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        rdy;
    logic [31:0] rdat;
    logic [9:0]  flags;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [137:0] snap();
    return {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_re, mem_we, busy, owner,
            mem_addr, mem_wdata, m0_rdata, m1_rdata};
  endfunction

  task automatic chk(input string nm, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    mem_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Both ports request together; 'first' is the port expected to be served first
  task automatic both_round(input logic first);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0A0A;
    cycle();
    chk("rr_gnt_first", {m0_gnt, m1_gnt}, first ? 2'b01 : 2'b10);
    cycle();
    chk("rr_done_first", {m0_done, m1_done}, first ? 2'b01 : 2'b10);
    cycle();
    if (first) m1_req = 1'b0; else m0_req = 1'b0;
    cycle();
    chk("rr_gnt_second", {m0_gnt, m1_gnt}, first ? 2'b10 : 2'b01);
    cycle();
    chk("rr_done_second", {m0_done, m1_done}, first ? 2'b10 : 2'b01);
    cycle();
    if (first) m0_req = 1'b0; else m1_req = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;

    //                m0 req we addr      wdata  m1 req we addr      wdata         rdy rdat          flags           addr      wdata         rd0           rd1
    tbl[0]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        10'b1000001010, 32'h10, 32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        10'b0000001010, 32'h10, 32'h0,        32'h0,        32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        10'b0000001010, 32'h10, 32'h0,        32'h0,        32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'hDEADBEEF, 10'b0010000010, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h11111111, 10'b0000000000, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        10'b0000000000, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0,        10'b0100000111, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b1, 32'hAAAA5555, 10'b0001000011, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0,        10'b0000000001, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0,        10'b0000000001, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h40, 32'h12345678, 1'b1, 32'hFFFF0000, 10'b0000000001, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0,        10'b0000000001, 32'h40, 32'h12345678, 32'hDEADBEEF, 32'h0};

    do_reset();
    chk("reset_state", snap(), {10'b0000000001, 32'h0, 32'h0, 32'h0, 32'h0});

    // m0 read with two wait states, m1 zero-wait write, mem_ready outside ACCESS
    for (int i = 0; i < 12; i++) begin
      m0_req = tbl[i].m0_req; m0_we = tbl[i].m0_we; m0_addr = tbl[i].m0_addr; m0_wdata = tbl[i].m0_wdata;
      m1_req = tbl[i].m1_req; m1_we = tbl[i].m1_we; m1_addr = tbl[i].m1_addr; m1_wdata = tbl[i].m1_wdata;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdat;
      cycle();
      chk($sformatf("vec%0d", i), snap(), {tbl[i].flags, tbl[i].addr, tbl[i].wdata, tbl[i].rd0, tbl[i].rd1});
    end

    // Simultaneous requests after reset: strict alternation 0,1 per round
    do_reset();
    for (int r = 0; r < 4; r++) both_round(1'b0);
    chk("rr_owner_after", owner, 1'b1);

    // Reset in the middle of an access
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; mem_ready = 1'b0;
    cycle();
    chk("rst_pre_gnt", {m0_gnt, mem_re, busy}, 3'b111);
    cycle();
    rst = 1'b1;
    #1;
    chk("rst_async_clear", {mem_re, mem_we, busy, m0_done, m1_done, owner}, 6'b000001);
    m0_req = 1'b0;
    cycle();
    cycle();
    chk("rst_no_done", {m0_done, m1_done, mem_re}, 3'b000);
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h24; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    cycle();
    chk("post_rst_gnt", {m0_gnt, mem_re, mem_addr}, {2'b11, 32'h24});
    cycle();
    chk("post_rst_done", {m0_done, m0_err, mem_re, m0_rdata}, {3'b100, 32'hCAFEF00D});
    cycle();
    m0_req = 1'b0; mem_ready = 1'b0;

    // Owner is now port 0, so contention must favour port 1
    both_round(1'b1);

    // Memory never answers
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30; mem_ready = 1'b0; mem_rdata = 32'h77777777;
    cycle();
    chk("stall_gnt", {m0_gnt, mem_re}, 2'b11);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("tmo_wait%0d", i), {mem_re, m0_done}, 2'b10);
    end
    cycle();
    chk("tmo_abort", {m0_done, m0_err, mem_re, m0_rdata}, {3'b110, 32'h0});
    cycle();
    m0_req = 1'b0;
    cycle();
    chk("tmo_idle", {busy, m0_err}, 2'b00);
    m0_req = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
    cycle();
    chk("tmo_ready_wins", {m0_done, m0_err, m0_rdata}, {2'b10, 32'h5A5A5A5A});
    cycle();
    m0_req = 1'b0; mem_ready = 1'b0;
`else
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (m0_done || m1_done) done_seen++;
    end
    chk("stall_still_busy", {busy, mem_re, m0_err}, 3'b110);
    chk("stall_no_done", done_seen, 0);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
